// File: rtl/ifu_pkg.sv
// Shared types and constants for the mipslite instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifu_pkg;

  // Fetch FSM state encodings.
  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_FETCH = 2'd1,
    IFU_DROP  = 2'd2,
    IFU_FULL  = 2'd3
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // One fetched instruction together with its address.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_t;

  // Branch/jump targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_if_id_reg.sv
// IF/ID pipeline register plus one skid entry for words acked during a stall.
// Latency: 1 cycle from load (or skid drain) to id_valid.
// Backpressure: hold freezes the ID register; a load under hold parks in the skid.
module ifu_if_id_reg
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  fetch_t      load_dat,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [15:0] id_imm16,
  output logic        skid_valid
);

  fetch_t skid_dat;
  fetch_t src_dat;

  // A parked skid word is always older than anything arriving, so it drains first.
  always_comb begin
    src_dat = skid_valid ? skid_dat : load_dat;
  end

  // ID register and skid update; flush wins, then hold, then drain/load/bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
      id_pc4     <= '0;
      id_imm16   <= '0;
      skid_valid <= 1'b0;
      skid_dat   <= '0;
    end else if (flush) begin
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (hold) begin
      if (load) begin
        skid_valid <= 1'b1;
        skid_dat   <= load_dat;
      end
    end else if (skid_valid || load) begin
      id_valid   <= 1'b1;
      id_instr   <= src_dat.instr;
      id_pc      <= src_dat.pc;
      id_pc4     <= src_dat.pc + 32'd4;
      id_imm16   <= src_dat.instr[15:0];
      skid_valid <= 1'b0;
    end else begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch: owns the PC, runs the imem req/ack handshake, feeds IF/ID.
// Latency: ack in cycle N gives id_valid in cycle N+1; 1 instr/cycle with zero-wait memory.
// Backpressure: stall freezes ID; one acked word parks in the skid and fetch pauses (FULL).
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [15:0] id_imm16
);

  ifu_state_e  state;
  logic [31:0] pc;
  // Redirect target held while the stale request drains; pc must stay on the
  // stale address so imem_addr remains stable until that request is acked.
  logic [31:0] tgt;
  logic [31:0] redir_addr;
  logic        load;
  logic        hold;
  logic        skid_valid;
  fetch_t      load_dat;

  assign imem_addr  = pc;
  assign redir_addr = word_align(redirect_pc);
  assign load       = (state == IFU_FETCH) && imem_ack && !redirect_valid;
  assign hold       = stall && id_valid;
  assign load_dat   = '{instr: imem_rdata, pc: pc};

  // Fetch FSM with registered request; redirect outranks ack and stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IFU_IDLE;
      pc       <= RESET_PC;
      tgt      <= RESET_PC;
      imem_req <= 1'b0;
    end else begin
      case (state)
        IFU_IDLE: begin
          if (redirect_valid) pc <= redir_addr;
          state    <= IFU_FETCH;
          imem_req <= 1'b1;
        end
        IFU_FETCH: begin
          if (redirect_valid) begin
            if (imem_ack) begin
              pc <= redir_addr;
            end else begin
              tgt   <= redir_addr;
              state <= IFU_DROP;
            end
          end else if (imem_ack) begin
            pc <= pc + 32'd4;
            if (hold) begin
              state    <= IFU_FULL;
              imem_req <= 1'b0;
            end
          end
        end
        IFU_DROP: begin
          if (imem_ack) begin
            pc    <= redirect_valid ? redir_addr : tgt;
            state <= IFU_FETCH;
          end else if (redirect_valid) begin
            tgt <= redir_addr;
          end
        end
        IFU_FULL: begin
          if (redirect_valid) begin
            pc       <= redir_addr;
            state    <= IFU_FETCH;
            imem_req <= 1'b1;
          end else if (!stall) begin
            state    <= IFU_FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= IFU_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  ifu_if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .flush      (redirect_valid),
    .hold       (hold),
    .load_dat   (load_dat),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .id_imm16   (id_imm16),
    .skid_valid (skid_valid)
  );

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu with a memory model returning instr = addr.
// Latency: memory acks with the request when lat==0, else in the lat-th request cycle.
// Backpressure: stall and redirect are driven directly from the scenario tasks.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [15:0] id_imm16;

  int   tests = 0;
  int   fails = 0;
  int   lat = 0;
  int   wait_cnt;
  logic mem_ack_r;

  always #5 clk = ~clk;

  ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4),
    .id_imm16       (id_imm16)
  );

  assign imem_ack   = (lat == 0) ? imem_req : mem_ack_r;
  assign imem_rdata = imem_addr;

  // Multi-cycle memory: count request cycles, pulse ack for one cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 0;
      mem_ack_r <= 1'b0;
    end else if (lat != 0) begin
      if (mem_ack_r) begin
        mem_ack_r <= 1'b0;
        wait_cnt  <= 0;
      end else if (imem_req) begin
        if (wait_cnt == lat - 2) mem_ack_r <= 1'b1;
        else wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Hold reset for two cycles, release on a falling edge (call it n0).
  task automatic apply_reset(input int l);
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lat = l;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    @(negedge clk);
    rst_n = 1'b0; lat = 0;
    @(negedge clk);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", imem_req); end
    tests++; if (imem_addr !== 32'h3000) begin fails++; $display("FAIL rst_addr got %h want 00003000", imem_addr); end
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_id_valid got %b want 0", id_valid); end
    tests++; if ({id_instr, id_pc, id_pc4} !== 96'h0) begin fails++; $display("FAIL rst_id_regs got %h %h %h want 0", id_instr, id_pc, id_pc4); end
    tests++; if (id_imm16 !== 16'h0) begin fails++; $display("FAIL rst_imm16 got %h want 0", id_imm16); end
    tests++; if (dut.u_if_id.skid_valid !== 1'b0) begin fails++; $display("FAIL rst_skid got %b want 0", dut.u_if_id.skid_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL first_req got %b want 1", imem_req); end
    tests++; if (imem_addr !== 32'h3000) begin fails++; $display("FAIL first_addr got %h want 00003000", imem_addr); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = 32'h3000 + 32'(4 * k);
      tests++; if (id_valid !== 1'b1) begin fails++; $display("FAIL zw_valid[%0d] got %b want 1", k, id_valid); end
      tests++; if (id_pc !== e) begin fails++; $display("FAIL zw_pc[%0d] got %h want %h", k, id_pc, e); end
      tests++; if (id_pc4 !== e + 32'd4) begin fails++; $display("FAIL zw_pc4[%0d] got %h want %h", k, id_pc4, e + 32'd4); end
      tests++; if (id_instr !== e) begin fails++; $display("FAIL zw_instr[%0d] got %h want %h", k, id_instr, e); end
      tests++; if (id_imm16 !== e[15:0]) begin fails++; $display("FAIL zw_imm16[%0d] got %h want %h", k, id_imm16, e[15:0]); end
      tests++; if (imem_addr !== e + 32'd4) begin fails++; $display("FAIL zw_addr[%0d] got %h want %h", k, imem_addr, e + 32'd4); end
    end
  endtask

  task automatic test_latency();
    logic        ev;
    logic [31:0] ep;
    logic [31:0] ea;
    apply_reset(3);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      ev = (i >= 4) && (((i - 4) % 3) == 0);
      ea = 32'h3000 + 32'(4 * ((i - 1) / 3));
      tests++; if (id_valid !== ev) begin fails++; $display("FAIL lat_valid[%0d] got %b want %b", i, id_valid, ev); end
      tests++; if (imem_addr !== ea) begin fails++; $display("FAIL lat_addr[%0d] got %h want %h", i, imem_addr, ea); end
      if (ev) begin
        ep = 32'h3000 + 32'(4 * ((i - 4) / 3));
        tests++; if (id_pc !== ep) begin fails++; $display("FAIL lat_pc[%0d] got %h want %h", i, id_pc, ep); end
      end
    end
    // Asynchronous reset while the 0x300C request is outstanding.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL midrst_req got %b want 0", imem_req); end
    tests++; if (imem_addr !== 32'h3000) begin fails++; $display("FAIL midrst_addr got %h want 00003000", imem_addr); end
    tests++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin fails++; $display("FAIL midrst_id got %b %h want 0 00000000", id_valid, id_pc); end
  endtask

  task automatic test_stall_skid();
    apply_reset(0);
    repeat (2) @(negedge clk);          // n2: ID holds 0x3000, ack for 0x3004
    stall = 1'b1;
    @(negedge clk);                      // n3: FULL
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL full_req got %b want 0", imem_req); end
    tests++; if (dut.u_if_id.skid_valid !== 1'b1) begin fails++; $display("FAIL full_skid got %b want 1", dut.u_if_id.skid_valid); end
    tests++; if (id_pc !== 32'h3000 || id_valid !== 1'b1) begin fails++; $display("FAIL full_hold got %b %h want 1 00003000", id_valid, id_pc); end
    @(negedge clk);                      // n4: still stalled
    tests++; if (imem_req !== 1'b0 || id_pc !== 32'h3000) begin fails++; $display("FAIL full_hold2 got %b %h want 0 00003000", imem_req, id_pc); end
    stall = 1'b0;
    @(negedge clk);                      // n5: skid drained
    tests++; if (id_pc !== 32'h3004 || id_valid !== 1'b1) begin fails++; $display("FAIL drain_pc got %b %h want 1 00003004", id_valid, id_pc); end
    tests++; if (dut.u_if_id.skid_valid !== 1'b0) begin fails++; $display("FAIL drain_skid got %b want 0", dut.u_if_id.skid_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin fails++; $display("FAIL drain_req got %b %h want 1 00003008", imem_req, imem_addr); end
    @(negedge clk);
    tests++; if (id_pc !== 32'h3008) begin fails++; $display("FAIL after_drain_pc got %h want 00003008", id_pc); end
  endtask

  task automatic test_redirect_drop();
    apply_reset(3);
    repeat (7) @(negedge clk);          // n7: request for 0x3008 just started
    tests++; if (imem_addr !== 32'h3008 || id_pc !== 32'h3004) begin fails++; $display("FAIL pre_redir got %h %h want 00003008 00003004", imem_addr, id_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h4003;
    @(negedge clk);                      // n8: DROP
    redirect_valid = 1'b0;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin fails++; $display("FAIL drop_addr got %b %h want 1 00003008", imem_req, imem_addr); end
    @(negedge clk);                      // n9: stale ack
    tests++; if (imem_addr !== 32'h3008) begin fails++; $display("FAIL drop_stable got %h want 00003008", imem_addr); end
    @(negedge clk);                      // n10
    tests++; if (imem_addr !== 32'h4000 || imem_req !== 1'b1) begin fails++; $display("FAIL redir_req got %b %h want 1 00004000", imem_req, imem_addr); end
    for (int i = 8; i <= 12; i++) begin
      if (i > 10) @(negedge clk);
      tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL drop_bubble[%0d] got %b (pc %h) want 0", i, id_valid, id_pc); end
    end
    @(negedge clk);                      // n13
    tests++; if (id_valid !== 1'b1 || id_pc !== 32'h4000) begin fails++; $display("FAIL redir_first got %b %h want 1 00004000", id_valid, id_pc); end
    tests++; if (id_pc4 !== 32'h4004 || id_instr !== 32'h4000) begin fails++; $display("FAIL redir_first_dat got %h %h want 00004004 00004000", id_pc4, id_instr); end
  endtask

  task automatic test_redirect_ack_stall();
    apply_reset(0);
    repeat (2) @(negedge clk);          // n2: ID 0x3000, ack for 0x3004
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h5000;
    @(negedge clk);                      // n3
    redirect_valid = 1'b0; stall = 1'b0;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL ra_valid got %b want 0", id_valid); end
    tests++; if (dut.u_if_id.skid_valid !== 1'b0) begin fails++; $display("FAIL ra_skid got %b want 0", dut.u_if_id.skid_valid); end
    tests++; if (imem_addr !== 32'h5000 || imem_req !== 1'b1) begin fails++; $display("FAIL ra_addr got %b %h want 1 00005000", imem_req, imem_addr); end
    @(negedge clk);
    tests++; if (id_valid !== 1'b1 || id_pc !== 32'h5000) begin fails++; $display("FAIL ra_first got %b %h want 1 00005000", id_valid, id_pc); end
  endtask

  task automatic test_wrap();
    apply_reset(0);
    @(negedge clk);                      // n1: ack for 0x3000, redirect same cycle
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);                      // n2
    redirect_valid = 1'b0;
    tests++; if (imem_addr !== 32'hFFFF_FFFC || id_valid !== 1'b0) begin fails++; $display("FAIL wrap_tgt got %h %b want fffffffc 0", imem_addr, id_valid); end
    @(negedge clk);                      // n3
    tests++; if (id_pc !== 32'hFFFF_FFFC || id_imm16 !== 16'hFFFC) begin fails++; $display("FAIL wrap_pc got %h %h want fffffffc fffc", id_pc, id_imm16); end
    tests++; if (id_pc4 !== 32'h0) begin fails++; $display("FAIL wrap_pc4 got %h want 00000000", id_pc4); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr got %h want 00000000", imem_addr); end
    @(negedge clk);
    tests++; if (id_pc !== 32'h0 || id_pc4 !== 32'h4) begin fails++; $display("FAIL wrap_next got %h %h want 00000000 00000004", id_pc, id_pc4); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall_skid();
    test_redirect_drop();
    test_redirect_ack_stall();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
